// File: rtl/parity_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : parity_uart_rx
// Description : UART receiver. Frame is start(0), DATA_BITS data bits LSB
//               first, one even-parity bit and one stop(1). The line is
//               double-flop synchronized. A stop bit sampled low raises
//               frame_err and holds the receiver until the line returns high.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 sync1;
    logic                 sync2;
    logic                 rx_prev;
    logic                 fall;
    logic                 sample;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection;
    // all three sit at the idle level (1) out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= rx;
            sync2   <= sync1;
            rx_prev <= sync2;
        end
    end

    assign fall = rx_prev & ~sync2;
    assign busy = (state != IDLE);

    // Sample strobe: half a bit into the start bit, then every full bit period.
    always_comb begin
        sample = 1'b0;
        case (state)
            START:              sample = (cnt == HALF_M1);
            DATA, PARITY, STOP: sample = (cnt == FULL_M1);
            default:            sample = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; line edges outside IDLE are ignored, only sample points matter.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (fall) state_next = START;
            START:      if (sample) state_next = sync2 ? IDLE : DATA;
            DATA:       if (sample && (bit_cnt == LAST_BIT)) state_next = PARITY;
            PARITY:     if (sample) state_next = STOP;
            STOP:       if (sample) state_next = sync2 ? IDLE : BREAK_WAIT;
            BREAK_WAIT: if (sync2) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Bit-period and data-bit counters; both held at zero while waiting for a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_cnt <= '0;
        end else if ((state == IDLE) || (state == BREAK_WAIT)) begin
            cnt     <= '0;
            bit_cnt <= '0;
        end else begin
            cnt <= sample ? '0 : cnt + CW'(1);
            if ((state == DATA) && sample) begin
                bit_cnt <= bit_cnt + BW'(1);
            end
        end
    end

    // Datapath: shift in data bits, evaluate parity, publish the frame at the stop sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            par_bad    <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if ((state == DATA) && sample) begin
                shreg <= {sync2, shreg[DATA_BITS-1:1]};
            end
            if ((state == PARITY) && sample) begin
                par_bad <= (^shreg) ^ sync2;
            end
            if ((state == STOP) && sample) begin
                valid      <= 1'b1;
                data       <= shreg;
                parity_err <= par_bad;
                frame_err  <= ~sync2;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parity_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_parity_uart_rx
// Description : Scoreboard bench for parity_uart_rx (CLKS_PER_BIT=16,
//               DATA_BITS=8). Frames are pushed to a queue when driven and
//               popped when the receiver pulses valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_uart_rx;

    localparam int CPB = 16;

    typedef struct {
        logic [7:0] d;
        logic       perr;
        logic       ferr;
        int         start;
        bit         lat;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    exp_t sb[$];
    int   total  = 0;
    int   bad    = 0;
    int   cyc    = 0;
    int   vcount = 0;

    parity_uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every valid pulse is compared against the oldest pending frame.
    always @(negedge clk) begin
        if (rst_n && valid) begin
            vcount++;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("data", {24'd0, data}, {24'd0, e.d});
                check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
                check("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
                if (e.lat) begin
                    check("latency_ok", {31'd0, ((cyc - e.start) >= 169) && ((cyc - e.start) <= 171)}, 32'd1);
                end
            end
        end
    end

    // Hold rx at one level for one bit period; caller is aligned to a falling clock edge.
    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input bit lat);
        exp_t e;
        e.d     = d;
        e.perr  = (^d) ^ par;
        e.ferr  = ~stop;
        e.start = cyc;
        e.lat   = lat;
        sb.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain;
        for (int i = 0; (i < 400) && (sb.size() > 0); i++) @(negedge clk);
        check("drain", sb.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen_busy;
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_perr", {31'd0, parity_err}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        idle(5);

        // Clean frame with latency check
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        idle(4);
        drain();
        check("nvalid_a5", vcount, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Wrong parity bit
        send_frame(8'h01, 1'b0, 1'b1, 1'b0);
        idle(4);
        drain();
        check("nvalid_01", vcount, 32'd2);

        // Stop bit low, then line held low (break)
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        check("break_busy", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        check("break_exit_busy", {31'd0, busy}, 32'd0);
        idle(20);
        drain();
        check("nvalid_break", vcount, 32'd3);

        // Short glitch from idle
        rx = 1'b0;
        seen_busy = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen_busy |= busy;
        end
        rx = 1'b1;
        n = 0;
        while ((busy || !seen_busy) && n < 10) begin
            @(negedge clk);
            seen_busy |= busy;
            n++;
        end
        check("glitch_seen_busy", {31'd0, seen_busy}, 32'd1);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        idle(20);
        check("nvalid_glitch", vcount, 32'd3);
        check("hold_data", {24'd0, data}, 32'h3C);
        check("hold_ferr", {31'd0, frame_err}, 32'd1);

        // Back-to-back frames, no idle bits
        send_frame(8'h55, 1'b0, 1'b1, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b1, 1'b0);
        idle(4);
        drain();
        check("nvalid_b2b", vcount, 32'd5);

        // Reset in the middle of the data bits
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_data", {24'd0, data}, 32'd0);
        rst_n = 1'b1;
        idle(200);
        check("nvalid_abort", vcount, 32'd5);
        send_frame(8'h0F, 1'b0, 1'b1, 1'b0);
        idle(4);
        drain();
        check("nvalid_0f", vcount, 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
